// File: rtl/ula_arbiter.sv
// ----------------------------------------------------------------------------
// ula_arbiter
//
// Sequencer and two-port arbiter in front of the shared 32-bit ALU
// (ula_32_bits). Each requester raises Req_x with its operation select and
// operands, then holds them until Done_x. One request is granted at a time.
// The winner's select and operands are registered onto the ALU drive outputs
// and held for ALU_LATENCY cycles. The ALU result and overflow are then
// captured and returned with a one-cycle Done_x pulse.
//
// Parameters
//   DATA_WIDTH     operand / result width
//   SEL_WIDTH      ALU operation select width
//   ALU_LATENCY    cycles from stable ALU inputs to valid Ula_out (1..7)
//   FIXED_PRIORITY 0 = round-robin on ties, 1 = port 0 wins ties
//
// Ports
//   Clock_in        clock, rising edge
//   Signal_reset_n  asynchronous active-low reset
//   Req_0/Req_1     request, held until the matching Done
//   Sel_x/A_x/B_x   operation select and operands of port x
//   Done_0/Done_1   one-cycle completion pulse of port x
//   Result/Overflow captured ALU result and overflow, held until next capture
//   Busy            high from the cycle after the grant up to the capture cycle
//   Grant_idx       port currently or last served
//   Ula_sel/Ula_data_1/Ula_data_2  drive the ALU Sel/Data_1/Data_2
//   Ula_out/Ula_overflow           from the ALU Out/Overflow
// ----------------------------------------------------------------------------
module ula_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int ALU_LATENCY    = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  Clock_in,
  input  logic                  Signal_reset_n,
  input  logic                  Req_0,
  input  logic                  Req_1,
  input  logic [SEL_WIDTH-1:0]  Sel_0,
  input  logic [SEL_WIDTH-1:0]  Sel_1,
  input  logic [DATA_WIDTH-1:0] A_0,
  input  logic [DATA_WIDTH-1:0] B_0,
  input  logic [DATA_WIDTH-1:0] A_1,
  input  logic [DATA_WIDTH-1:0] B_1,
  output logic                  Done_0,
  output logic                  Done_1,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  Busy,
  output logic                  Grant_idx,
  output logic [SEL_WIDTH-1:0]  Ula_sel,
  output logic [DATA_WIDTH-1:0] Ula_data_1,
  output logic [DATA_WIDTH-1:0] Ula_data_2,
  input  logic [DATA_WIDTH-1:0] Ula_out,
  input  logic                  Ula_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam logic       FIXED    = (FIXED_PRIORITY != 0);
  // Counter value on the last EXEC cycle; the counter starts at 0 on grant.
  localparam logic [2:0] LAT_LAST = 3'(ALU_LATENCY - 1);

  state_t                r_state, w_state_next;
  logic [2:0]            r_cnt, w_cnt_next;
  logic                  r_grant, w_grant_next;
  logic [SEL_WIDTH-1:0]  r_sel, w_sel_next;
  logic [DATA_WIDTH-1:0] r_data_1, w_data_1_next;
  logic [DATA_WIDTH-1:0] r_data_2, w_data_2_next;
  logic [DATA_WIDTH-1:0] r_result, w_result_next;
  logic                  r_ovf, w_ovf_next;
  logic                  r_done_0, w_done_0_next;
  logic                  r_done_1, w_done_1_next;

  logic [1:0]            w_req;
  logic [1:0]            w_done_now;
  logic [1:0]            w_elig;
  logic                  w_winner;

  assign w_req      = {Req_1, Req_0};
  assign w_done_now = {r_done_1, r_done_0};

  // A request is still high during its own Done cycle because the requester
  // only sees Done then; that cycle's request is treated as consumed.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      assign w_elig[gi] = w_req[gi] & ~w_done_now[gi];
    end
  endgenerate

  // Winner: a lone eligible port wins; ties go to port 0 under fixed priority,
  // otherwise to the port that was not served last.
  always_comb begin
    w_winner = w_elig[1];
    if (w_elig[0] && w_elig[1]) begin
      w_winner = FIXED ? 1'b0 : ~r_grant;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_grant_next  = r_grant;
    w_sel_next    = r_sel;
    w_data_1_next = r_data_1;
    w_data_2_next = r_data_2;
    w_result_next = r_result;
    w_ovf_next    = r_ovf;
    w_done_0_next = 1'b0;
    w_done_1_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          // Operands are captured here so later requester changes cannot
          // disturb the operation in flight.
          w_grant_next  = w_winner;
          w_sel_next    = w_winner ? Sel_1 : Sel_0;
          w_data_1_next = w_winner ? A_1 : A_0;
          w_data_2_next = w_winner ? B_1 : B_0;
          w_cnt_next    = 3'd0;
          w_state_next  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_cnt_next = r_cnt + 3'd1;
        if (r_cnt == LAT_LAST) begin
          w_state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_result_next = Ula_out;
        w_ovf_next    = Ula_overflow;
        w_done_0_next = ~r_grant;
        w_done_1_next = r_grant;
        w_state_next  = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock_in or negedge Signal_reset_n) begin
    if (!Signal_reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_grant  <= 1'b1;
      r_sel    <= '0;
      r_data_1 <= '0;
      r_data_2 <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_done_0 <= 1'b0;
      r_done_1 <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_grant  <= w_grant_next;
      r_sel    <= w_sel_next;
      r_data_1 <= w_data_1_next;
      r_data_2 <= w_data_2_next;
      r_result <= w_result_next;
      r_ovf    <= w_ovf_next;
      r_done_0 <= w_done_0_next;
      r_done_1 <= w_done_1_next;
    end
  end

  assign Done_0     = r_done_0;
  assign Done_1     = r_done_1;
  assign Result     = r_result;
  assign Overflow   = r_ovf;
  assign Busy       = (r_state != ST_IDLE);
  assign Grant_idx  = r_grant;
  assign Ula_sel    = r_sel;
  assign Ula_data_1 = r_data_1;
  assign Ula_data_2 = r_data_2;

endmodule
